vz_loader: RTL
==============

VZ_LOADER -- requirements
Module: vz_loader

Interface
REQ-001 SHALL have parameter INDEX, default 8'd1, the ioctl_index value whose downloads are parsed.
REQ-002 SHALL have parameter ADDR_W, default 16, the RAM address width (range 14..16).
REQ-003 SHALL have parameter PATCH_EN, default 1, enabling BASIC pointer patching after a type-F0 load.
REQ-004 SHALL have parameter MAGIC_CHK, default 1, enabling header magic check.
REQ-005 clk_sys  in  1  system clock; all logic on the rising edge.
REQ-006 RESET  in  1  asynchronous, active-low reset.
REQ-007 dn_download  in  1  download active.
REQ-008 dn_index  in  8  download slot.
REQ-009 dn_wr  in  1  one-cycle byte strobe.
REQ-010 dn_addr  in  16  byte offset within file.
REQ-011 dn_data  in  8  byte value.
REQ-012 ram_addr  out  ADDR_W  RAM write address.
REQ-013 ram_din  out  8  RAM write data.
REQ-014 ram_we  out  1  one-cycle write strobe.
REQ-015 busy  out  1  high from first accepted byte until DONE/ERR.
REQ-016 done  out  1  one-cycle pulse on successful completion.
REQ-017 err  out  1  sticky error flag, cleared by next accepted download start.
REQ-018 file_type  out  8  header byte 21 (F0 BASIC, F1 binary).
REQ-019 start_addr  out  16  header bytes 22 (low), 23 (high).
REQ-020 end_addr  out  16  start_addr + payload byte count.

Function
REQ-021 A byte SHALL be accepted only when dn_download=1, dn_wr=1, dn_index=INDEX; all others ignored.
REQ-022 States: IDLE, HDR, DATA, PATCH, DONE, ERR.
REQ-023 IDLE->HDR on rising edge of dn_download with dn_index=INDEX; err, file_type, start_addr, end_addr cleared on that edge.
REQ-024 HDR: offsets 0..23 captured; offsets 0..3 compared against "VZF0" or "VZFO" when MAGIC_CHK=1; offsets 4..20 (name) discarded.
REQ-025 Magic mismatch SHALL go to ERR on the cycle after offset 3 is accepted; no RAM write occurs for that file.
REQ-026 HDR->DATA after offset 23 accepted; end_addr loaded with start_addr.
REQ-027 DATA: byte at offset N>=24 SHALL be written to start_addr+(N-24), truncated to ADDR_W bits; ram_we asserted exactly 1 cycle after the accepting dn_wr (latency 1); end_addr incremented on each write.
REQ-028 Target address exceeding 16'hFFFF (16-bit carry) SHALL set err, suppress the write, and go to ERR.
REQ-029 dn_download falling in HDR (fewer than 24 bytes) SHALL go to ERR.
REQ-030 dn_download falling in DATA: if PATCH_EN=1 and file_type=8'hF0 go to PATCH, else DONE.
REQ-031 PATCH: four consecutive single-cycle writes, one per cycle: 16'h78A4<=start low, 16'h78A5<=start high, 16'h78F9<=end low, 16'h78FA<=end high; then DONE.
REQ-032 DONE pulses done for one cycle, returns to IDLE. ERR asserts err, returns to IDLE next cycle; err remains set.
REQ-033 Rising edge of dn_download in any non-IDLE state SHALL abort the current file (no patch, no done) and restart at HDR.
REQ-034 ram_we SHALL never be high in two states' cycles simultaneously; PATCH writes never overlap DATA writes.
REQ-035 busy=1 in HDR, DATA, PATCH; 0 elsewhere.

Reset
REQ-036 RESET=0 SHALL immediately force IDLE, ram_we=0, busy=0, done=0, err=0, ram_addr=0, ram_din=0, file_type=0, start_addr=0, end_addr=0.
REQ-037 Reset asserted mid-download SHALL abandon the file; after release, bytes are ignored until the next dn_download rising edge.

Verification
REQ-038 "VZF0", type F1, start 16'h8000, 3 payload bytes AA,BB,CC -> writes 8000=AA,8001=BB,8002=CC, each 1 cycle after dn_wr; end_addr=16'h8003; done pulse; no patch writes.
REQ-039 Type F0, start 16'h7AE9, 2 bytes -> 2 data writes, then 78A4=E9, 78A5=7A, 78F9=EB, 78FA=7A on 4 consecutive cycles; done pulse.
REQ-040 Magic "XXXX" with MAGIC_CHK=1 -> err=1 after offset 3, zero ram_we for whole file, no done.
REQ-041 Start 16'hFFFE, 3 payload bytes -> writes FFFE, FFFF; third suppressed; err=1; state IDLE.
REQ-042 dn_index=0 download of 100 bytes -> no ram_we, busy stays 0.
REQ-043 RESET low after 10 payload bytes -> outputs zero immediately; subsequent dn_wr within same download ignored.

Source files
------------

// File: rtl/vz_loader.sv
// VZ snapshot loader: parses a VZ header from the ioctl download stream, writes
// the payload into RAM and optionally patches the BASIC program pointers.
module vz_loader #(
  parameter logic [7:0] INDEX     = 8'd1,
  parameter int         ADDR_W    = 16,
  parameter bit         PATCH_EN  = 1'b1,
  parameter bit         MAGIC_CHK = 1'b1
) (
  input  logic              clk_sys,
  input  logic              RESET,
  input  logic              dn_download,
  input  logic [7:0]        dn_index,
  input  logic              dn_wr,
  input  logic [15:0]       dn_addr,
  input  logic [7:0]        dn_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        file_type,
  output logic [15:0]       start_addr,
  output logic [15:0]       end_addr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PATCH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [15:0] PATCH_A0 = 16'h78A4;
  localparam logic [15:0] PATCH_A1 = 16'h78A5;
  localparam logic [15:0] PATCH_A2 = 16'h78F9;
  localparam logic [15:0] PATCH_A3 = 16'h78FA;

  logic [2:0]        state_q, state_d, st;
  logic              dl_q;
  logic              magic_ok_q, magic_ok_d;
  logic [1:0]        pidx_q, pidx_d;
  logic [7:0]        ftype_q, ftype_d;
  logic [15:0]       start_q, start_d;
  logic [15:0]       end_q, end_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;

  logic        idx_ok, acc, rise, fall, start_edge, ok3;
  logic [16:0] target;

  always_comb begin
    idx_ok     = (dn_index == INDEX);
    acc        = dn_download & dn_wr & idx_ok;
    rise       = dn_download & ~dl_q;
    fall       = ~dn_download & dl_q;
    start_edge = rise & idx_ok;
    target     = {1'b0, start_q} + {1'b0, dn_addr - 16'd24};
    ok3        = 1'b0;

    magic_ok_d = magic_ok_q;
    pidx_d     = pidx_q;
    ftype_d    = ftype_q;
    start_d    = start_q;
    end_d      = end_q;
    err_d      = err_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;

    // A new download restarts from any state; a byte in that same cycle is parsed as HDR.
    st = state_q;
    if (start_edge) begin
      st         = S_HDR;
      err_d      = 1'b0;
      ftype_d    = '0;
      start_d    = '0;
      end_d      = '0;
      magic_ok_d = 1'b1;
    end
    state_d = st;

    case (st)
      S_HDR: begin
        if (fall) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (acc && dn_addr < 16'd24) begin
          case (dn_addr[4:0])
            5'd0: magic_ok_d = magic_ok_d & (dn_data == 8'h56);
            5'd1: magic_ok_d = magic_ok_d & (dn_data == 8'h5A);
            5'd2: magic_ok_d = magic_ok_d & (dn_data == 8'h46);
            5'd3: begin
              ok3 = magic_ok_d & ((dn_data == 8'h30) | (dn_data == 8'h4F));
              if (MAGIC_CHK && !ok3) begin
                state_d = S_ERR;
                err_d   = 1'b1;
              end
            end
            5'd21: ftype_d = dn_data;
            5'd22: start_d = {start_d[15:8], dn_data};
            5'd23: begin
              start_d = {dn_data, start_d[7:0]};
              end_d   = {dn_data, start_d[7:0]};
              state_d = S_DATA;
            end
            default: ;
          endcase
        end
      end
      S_DATA: begin
        if (fall) begin
          pidx_d  = '0;
          state_d = (PATCH_EN && ftype_q == 8'hF0) ? S_PATCH : S_DONE;
        end else if (acc && dn_addr >= 16'd24) begin
          if (target[16]) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            we_d   = 1'b1;
            addr_d = target[ADDR_W-1:0];
            din_d  = dn_data;
            end_d  = end_q + 16'd1;
          end
        end
      end
      S_PATCH: begin
        we_d   = 1'b1;
        pidx_d = pidx_q + 2'd1;
        case (pidx_q)
          2'd0: begin addr_d = PATCH_A0[ADDR_W-1:0]; din_d = start_q[7:0];  end
          2'd1: begin addr_d = PATCH_A1[ADDR_W-1:0]; din_d = start_q[15:8]; end
          2'd2: begin addr_d = PATCH_A2[ADDR_W-1:0]; din_d = end_q[7:0];    end
          default: begin
            addr_d  = PATCH_A3[ADDR_W-1:0];
            din_d   = end_q[15:8];
            state_d = S_DONE;
          end
        endcase
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // dl_q resets high so a download still active across reset is not seen as a new start.
  always_ff @(posedge clk_sys or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      dl_q       <= 1'b1;
      magic_ok_q <= 1'b0;
      pidx_q     <= '0;
      ftype_q    <= '0;
      start_q    <= '0;
      end_q      <= '0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      dl_q       <= dn_download;
      magic_ok_q <= magic_ok_d;
      pidx_q     <= pidx_d;
      ftype_q    <= ftype_d;
      start_q    <= start_d;
      end_q      <= end_d;
      err_q      <= err_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
    end
  end

  assign ram_addr   = addr_q;
  assign ram_din    = din_q;
  assign ram_we     = we_q;
  assign busy       = (state_q == S_HDR) | (state_q == S_DATA) | (state_q == S_PATCH);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign file_type  = ftype_q;
  assign start_addr = start_q;
  assign end_addr   = end_q;

endmodule
